jump_redirect_ctrl: RTL

Sequencer for unconditional jumps (JAL/JALR) between decode and fetch. Accepts a decoded jump, computes its target, stalls decode while JALR's rs1 operand is not yet ready (no forwarding on the jump path), then hands a registered redirect to fetch with a valid/ready handshake. It also flushes the IF/ID slot, produces the link value (pc+4), and reports misaligned targets. A higher-priority pipeline flush (trap or EX-stage branch) can abort it.

---
 rtl/jump_redirect_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/jump_redirect_ctrl.sv
// Jump sequencer between decode and fetch: resolves JAL/JALR targets, waits on a
// not-ready JALR rs1, offers a registered redirect to fetch and produces the link value.
module jump_redirect_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        id_valid_i,
  input  logic        id_jal_i,
  input  logic        id_jalr_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_imm_i,
  input  logic [31:0] rs1_data_i,
  input  logic        rs1_ready_i,
  input  logic        pipe_flush_i,
  input  logic        if_ready_i,
  output logic        id_stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_if_id_o,
  output logic        link_valid_o,
  output logic [31:0] link_data_o,
  output logic        misalign_exc_o,
  output logic [31:0] misalign_addr_o,
  output logic        wait_timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RS1 = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imm_q, imm_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_data_q, link_data_d;
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;
  logic        timeout_q, timeout_d;

  logic        jmp;
  logic        accept;
  logic [31:0] tgt;
  logic [31:0] link_pc;
  logic [31:0] jal_tgt;
  logic [31:0] jalr_tgt;
  logic [31:0] wait_tgt;

  assign jmp      = id_valid_i & (id_jal_i | id_jalr_i);
  assign jal_tgt  = id_pc_i + id_imm_i;
  assign jalr_tgt = (rs1_data_i + id_imm_i) & 32'hFFFF_FFFE;
  // After a wait the decode-side fields may have moved on; use the latched copies.
  assign wait_tgt = (rs1_data_i + imm_q) & 32'hFFFF_FFFE;

  assign id_stall_o = jmp | (state_q != S_IDLE);

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    imm_d            = imm_q;
    cnt_d            = cnt_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    link_data_d      = link_data_q;
    misalign_addr_d  = misalign_addr_q;
    flush_d          = 1'b0;
    link_valid_d     = 1'b0;
    misalign_d       = 1'b0;
    timeout_d        = 1'b0;
    accept           = 1'b0;
    tgt              = 32'h0;
    link_pc          = id_pc_i;

    case (state_q)
      S_IDLE: begin
        if (jmp) begin
          if (id_jal_i) begin
            accept = 1'b1;
            tgt    = jal_tgt;
          end else if (rs1_ready_i) begin
            accept = 1'b1;
            tgt    = jalr_tgt;
          end else begin
            pc_d    = id_pc_i;
            imm_d   = id_imm_i;
            cnt_d   = 8'd0;
            state_d = S_WAIT_RS1;
          end
        end
      end
      S_WAIT_RS1: begin
        cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // Fires on the increment that reaches WAIT_MAX; saturation keeps it single-shot.
        timeout_d = (cnt_q == 8'(WAIT_MAX - 1));
        if (rs1_ready_i) begin
          accept  = 1'b1;
          tgt     = wait_tgt;
          link_pc = pc_q;
        end
      end
      S_REDIRECT: begin
        if (if_ready_i) begin
          redirect_valid_d = 1'b0;
          flush_d          = 1'b1;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      redirect_pc_d = tgt;
      if (tgt[1]) begin
        misalign_d      = 1'b1;
        misalign_addr_d = tgt;
        state_d         = S_IDLE;
      end else begin
        link_data_d      = link_pc + 32'd4;
        link_valid_d     = 1'b1;
        redirect_valid_d = 1'b1;
        state_d          = S_REDIRECT;
      end
    end

    // A later-stage abort wins over everything; data registers keep their last values.
    if (pipe_flush_i) begin
      state_d          = S_IDLE;
      pc_d             = pc_q;
      imm_d            = imm_q;
      cnt_d            = 8'd0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      link_data_d      = link_data_q;
      misalign_addr_d  = misalign_addr_q;
      flush_d          = 1'b0;
      link_valid_d     = 1'b0;
      misalign_d       = 1'b0;
      timeout_d        = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q          <= S_IDLE;
      pc_q             <= 32'h0;
      imm_q            <= 32'h0;
      cnt_q            <= 8'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      flush_q          <= 1'b0;
      link_valid_q     <= 1'b0;
      link_data_q      <= 32'h0;
      misalign_q       <= 1'b0;
      misalign_addr_q  <= 32'h0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      imm_q            <= imm_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      link_valid_q     <= link_valid_d;
      link_data_q      <= link_data_d;
      misalign_q       <= misalign_d;
      misalign_addr_q  <= misalign_addr_d;
      timeout_q        <= timeout_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_if_id_o    = flush_q;
  assign link_valid_o     = link_valid_q;
  assign link_data_o      = link_data_q;
  assign misalign_exc_o   = misalign_q;
  assign misalign_addr_o  = misalign_addr_q;
  assign wait_timeout_o   = timeout_q;

endmodule
